// File: rtl/tbl_arb.sv
// tbl_arb: round-robin arbiter for two table readers plus a table load engine.
// RUN serves reads with one-cycle latency; LOAD streams indexed entries into the table.
module tbl_arb #(
   parameter int TBL_DEPTH = 320
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_vld,
   input  logic        req1_vld,
   input  logic [67:0] req0_A,
   input  logic [67:0] req1_A,
   input  logic [2:0]  req0_xtra,
   input  logic [2:0]  req1_xtra,
   output logic        req0_rdy,
   output logic        req1_rdy,
   output logic        rsp0_vld,
   output logic        rsp1_vld,
   output logic [67:0] rsp_data,
   input  logic        ld_start,
   input  logic        ld_vld,
   input  logic        ld_last,
   input  logic [8:0]  ld_idx,
   input  logic [67:0] ld_data,
   output logic        ld_rdy,
   output logic [67:0] tbl_A,
   output logic [67:0] tbl_B,
   output logic [2:0]  tbl_xtra,
   output logic        tbl_read,
   output logic        tbl_write,
   input  logic [67:0] tbl_res,
   output logic        busy,
   output logic        ld_err,
   output logic [8:0]  ld_cnt
);
   typedef enum logic {RUN, LOAD} state_t;
   state_t      state_q;
   logic        prio_q, rsp0_q, rsp1_q, ld_err_q;
   logic [67:0] rsp_data_q;
   logic [8:0]  ld_cnt_q;
   logic        run, g0, g1, in_rng, beat;
   // ld_start steals the cycle so the load engine never overlaps a read
   assign run       = (state_q == RUN) && !ld_start;
   assign g0        = run && req0_vld && (!req1_vld || !prio_q);
   assign g1        = run && req1_vld && (!req0_vld || prio_q);
   assign beat      = (state_q == LOAD) && ld_vld;
   assign in_rng    = {23'd0, ld_idx} < TBL_DEPTH;
   assign req0_rdy  = g0;
   assign req1_rdy  = g1;
   assign tbl_read  = g0 || g1;
   assign tbl_write = beat && in_rng;
   assign tbl_A     = g0 ? req0_A : g1 ? req1_A : tbl_write ? ld_data : '0;
   assign tbl_xtra  = g0 ? req0_xtra : g1 ? req1_xtra : '0;
   assign tbl_B     = tbl_write ? {14'd0, ld_idx, 45'd0} : '0;
   assign busy      = state_q == LOAD;
   assign ld_rdy    = busy;
   assign rsp0_vld  = rsp0_q;
   assign rsp1_vld  = rsp1_q;
   assign rsp_data  = rsp_data_q;
   assign ld_err    = ld_err_q;
   assign ld_cnt    = ld_cnt_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         prio_q     <= 1'b0;
         rsp0_q     <= 1'b0;
         rsp1_q     <= 1'b0;
         rsp_data_q <= '0;
         ld_cnt_q   <= '0;
         ld_err_q   <= 1'b0;
      end else begin
         rsp0_q <= g0;
         rsp1_q <= g1;
         if (g0 || g1) begin
            rsp_data_q <= tbl_res;
            prio_q     <= g0;
         end
         if (state_q == RUN && ld_start) begin
            state_q  <= LOAD;
            ld_cnt_q <= '0;
            ld_err_q <= 1'b0;
         end
         if (beat && ld_last) state_q <= RUN;
         if (beat && !in_rng) ld_err_q <= 1'b1;
         if (tbl_write && ld_cnt_q < 9'(TBL_DEPTH)) ld_cnt_q <= ld_cnt_q + 9'd1;
      end
   end
endmodule
